// File: rtl/parser_rr_arb.sv
// parser_rr_arb: packet-granular round-robin arbiter that shares one parser
// between NUM_IN packet+metadata sources. A grant covers one metadata flit
// and one complete packet (sop..eop). The arbiter also keeps per-source
// packet counts, a total byte count and a sticky framing-error flag.
module parser_rr_arb #(
  parameter int NUM_IN      = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  // Width of the parser's metadata flit.
  parameter int META_WIDTH  = 64
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic [NUM_IN*DATA_WIDTH-1:0]      in_pkt_data,
  input  logic [NUM_IN-1:0]                 in_pkt_valid,
  input  logic [NUM_IN-1:0]                 in_pkt_sop,
  input  logic [NUM_IN-1:0]                 in_pkt_eop,
  input  logic [NUM_IN*EMPTY_WIDTH-1:0]     in_pkt_empty,
  output logic [NUM_IN-1:0]                 in_pkt_ready,

  input  logic [NUM_IN*META_WIDTH-1:0]      in_meta_data,
  input  logic [NUM_IN-1:0]                 in_meta_valid,
  output logic [NUM_IN-1:0]                 in_meta_ready,

  output logic [DATA_WIDTH-1:0]             out_pkt_data,
  output logic                              out_pkt_valid,
  output logic                              out_pkt_sop,
  output logic                              out_pkt_eop,
  output logic [EMPTY_WIDTH-1:0]            out_pkt_empty,
  input  logic                              out_pkt_ready,

  output logic [META_WIDTH-1:0]             out_meta_data,
  output logic                              out_meta_valid,
  input  logic                              out_meta_ready,

  output logic [$clog2(NUM_IN)-1:0]         out_sel,
  output logic [NUM_IN*32-1:0]              stats_pkt_cnt,
  output logic [63:0]                       stats_bytes,
  output logic                              proto_err
);

  localparam int SEL_W = $clog2(NUM_IN);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic                meta_done_reg, meta_done_next;
  logic                pkt_done_reg, pkt_done_next;
  // Set once the first flit of the current grant has been accepted.
  logic                flit_seen_reg, flit_seen_next;

  logic [31:0]         pkt_cnt_reg [NUM_IN];
  logic [63:0]         bytes_reg;
  logic                proto_err_reg;

  logic [DATA_WIDTH-1:0]  pkt_data_arr  [NUM_IN];
  logic [EMPTY_WIDTH-1:0] pkt_empty_arr [NUM_IN];
  logic [META_WIDTH-1:0]  meta_data_arr [NUM_IN];

  logic [NUM_IN-1:0]   eligible;
  logic                found;
  logic [SEL_W-1:0]    pick;
  logic [SEL_W:0]      scan_sum;
  logic [SEL_W-1:0]    scan_idx;

  logic                meta_hs;
  logic                pkt_hs;
  logic                frame_err;
  logic [63:0]         bytes_add;

  // Per-source slices of the flattened input buses and counter export.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
    assign pkt_data_arr[gi]  = in_pkt_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign pkt_empty_arr[gi] = in_pkt_empty[gi*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign meta_data_arr[gi] = in_meta_data[gi*META_WIDTH +: META_WIDTH];
    assign stats_pkt_cnt[gi*32 +: 32] = pkt_cnt_reg[gi];
  end

  assign eligible = in_meta_valid & in_pkt_valid;

  // Payload fields follow the granted source; only valids/readies are gated.
  assign out_pkt_data  = pkt_data_arr[sel_reg];
  assign out_pkt_sop   = in_pkt_sop[sel_reg];
  assign out_pkt_eop   = in_pkt_eop[sel_reg];
  assign out_pkt_empty = pkt_empty_arr[sel_reg];
  assign out_meta_data = meta_data_arr[sel_reg];
  assign out_sel       = sel_reg;
  assign stats_bytes   = bytes_reg;
  assign proto_err     = proto_err_reg;

  // Round-robin search: first eligible source at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
      if (scan_sum >= NUM_IN_W) begin
        scan_sum = scan_sum - NUM_IN_W;
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (!found && eligible[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // Pass-through handshakes for the granted source; each path shuts off once done.
  always_comb begin
    in_pkt_ready   = '0;
    in_meta_ready  = '0;
    out_pkt_valid  = 1'b0;
    out_meta_valid = 1'b0;
    if (state_reg == GRANT) begin
      if (!meta_done_reg) begin
        out_meta_valid         = in_meta_valid[sel_reg];
        in_meta_ready[sel_reg] = out_meta_ready;
      end
      if (!pkt_done_reg) begin
        out_pkt_valid         = in_pkt_valid[sel_reg];
        in_pkt_ready[sel_reg] = out_pkt_ready;
      end
    end
  end

  assign meta_hs = out_meta_valid & out_meta_ready;
  assign pkt_hs  = out_pkt_valid & out_pkt_ready;

  // First flit of a grant must carry sop; any later sop is a framing error.
  assign frame_err = pkt_hs & (flit_seen_reg ? out_pkt_sop : ~out_pkt_sop);

  // An eop flit only carries DATA_WIDTH/8 - empty valid bytes.
  assign bytes_add = out_pkt_eop ? (64'(BYTES) - 64'(out_pkt_empty)) : 64'(BYTES);

  // Next-state logic: arbitrate in IDLE, leave GRANT once both paths are done.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    rr_ptr_next    = rr_ptr_reg;
    meta_done_next = meta_done_reg;
    pkt_done_next  = pkt_done_reg;
    flit_seen_next = flit_seen_reg;
    case (state_reg)
      IDLE: begin
        meta_done_next = 1'b0;
        pkt_done_next  = 1'b0;
        flit_seen_next = 1'b0;
        if (found) begin
          state_next = GRANT;
          sel_next   = pick;
        end
      end
      GRANT: begin
        meta_done_next = meta_done_reg | meta_hs;
        pkt_done_next  = pkt_done_reg | (pkt_hs & out_pkt_eop);
        flit_seen_next = flit_seen_reg | pkt_hs;
        if (meta_done_next && pkt_done_next) begin
          state_next  = IDLE;
          rr_ptr_next = (sel_reg == LAST_SEL) ? '0 : sel_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM and grant bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      rr_ptr_reg    <= '0;
      meta_done_reg <= 1'b0;
      pkt_done_reg  <= 1'b0;
      flit_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      rr_ptr_reg    <= rr_ptr_next;
      meta_done_reg <= meta_done_next;
      pkt_done_reg  <= pkt_done_next;
      flit_seen_reg <= flit_seen_next;
    end
  end

  // Statistics and sticky framing error, updated on accepted flits only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        pkt_cnt_reg[i] <= '0;
      end
      bytes_reg     <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (pkt_hs) begin
        bytes_reg <= bytes_reg + bytes_add;
        if (out_pkt_eop) begin
          pkt_cnt_reg[sel_reg] <= pkt_cnt_reg[sel_reg] + 32'd1;
        end
      end
      if (frame_err) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parser_rr_arb.sv
// Directed bench for parser_rr_arb: single packet, round-robin order,
// wrap-around, metadata backpressure, framing errors and mid-packet reset.
module tb_parser_rr_arb;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int EW = 6;
  localparam int MW = 64;
  localparam logic [63:0] MK = 64'h5A5A_0000_0000_0000;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   in_pkt_data;
  logic [N-1:0]      in_pkt_valid;
  logic [N-1:0]      in_pkt_sop;
  logic [N-1:0]      in_pkt_eop;
  logic [N*EW-1:0]   in_pkt_empty;
  logic [N-1:0]      in_pkt_ready;
  logic [N*MW-1:0]   in_meta_data;
  logic [N-1:0]      in_meta_valid;
  logic [N-1:0]      in_meta_ready;
  logic [DW-1:0]     out_pkt_data;
  logic              out_pkt_valid;
  logic              out_pkt_sop;
  logic              out_pkt_eop;
  logic [EW-1:0]     out_pkt_empty;
  logic              out_pkt_ready;
  logic [MW-1:0]     out_meta_data;
  logic              out_meta_valid;
  logic              out_meta_ready;
  logic [1:0]        out_sel;
  logic [N*32-1:0]   stats_pkt_cnt;
  logic [63:0]       stats_bytes;
  logic              proto_err;

  int total = 0;
  int bad   = 0;

  parser_rr_arb #(
    .NUM_IN(N), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .META_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid),
    .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid),
    .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_ready(out_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid),
    .out_meta_ready(out_meta_ready),
    .out_sel(out_sel), .stats_pkt_cnt(stats_pkt_cnt),
    .stats_bytes(stats_bytes), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_all();
    in_pkt_data   = '0;
    in_pkt_valid  = '0;
    in_pkt_sop    = '0;
    in_pkt_eop    = '0;
    in_pkt_empty  = '0;
    in_meta_data  = '0;
    in_meta_valid = '0;
  endtask

  task automatic set_src(input int i, input logic mv, input logic pv, input logic s,
                         input logic e, input logic [EW-1:0] emp, input logic [63:0] d);
    in_meta_valid[i]           = mv;
    in_pkt_valid[i]            = pv;
    in_pkt_sop[i]              = s;
    in_pkt_eop[i]              = e;
    in_pkt_empty[i*EW +: EW]   = emp;
    in_pkt_data[i*DW +: DW]    = DW'(d);
    in_meta_data[i*MW +: MW]   = d ^ MK;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_all();
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_opv"}, 64'(out_pkt_valid), 64'd0);
    chk({tag, "_omv"}, 64'(out_meta_valid), 64'd0);
    chk({tag, "_ipr"}, 64'(in_pkt_ready), 64'd0);
    chk({tag, "_imr"}, 64'(in_meta_ready), 64'd0);
    chk({tag, "_sel"}, 64'(out_sel), 64'd0);
    chk({tag, "_bytes"}, stats_bytes, 64'd0);
    chk({tag, "_cnt_lo"}, stats_pkt_cnt[63:0], 64'd0);
    chk({tag, "_cnt_hi"}, stats_pkt_cnt[127:64], 64'd0);
    chk({tag, "_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    out_pkt_ready  = 1'b1;
    out_meta_ready = 1'b1;
    clr_all();
    do_reset();
    chk_zero("reset");

    // Single 3-flit packet from source 0, last empty=10 -> 64+64+54 bytes.
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 64'hD0);
    settle();
    chk("t1_idle_valid", 64'(out_pkt_valid), 64'd0);
    chk("t1_idle_ready", 64'(in_pkt_ready), 64'd0);
    tick(); settle();
    chk("t1_sel", 64'(out_sel), 64'd0);
    chk("t1_f1_valid", 64'(out_pkt_valid), 64'd1);
    chk("t1_f1_data", out_pkt_data[63:0], 64'hD0);
    chk("t1_meta_data", out_meta_data, 64'hD0 ^ MK);
    chk("t1_f1_ready", 64'(in_pkt_ready), 64'd1);
    chk("t1_meta_ready", 64'(in_meta_ready), 64'd1);
    tick();
    set_src(0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 64'hD1);
    settle();
    chk("t1_meta_off", 64'(out_meta_valid), 64'd0);
    chk("t1_f2_data", out_pkt_data[63:0], 64'hD1);
    chk("t1_bytes_f1", stats_bytes, 64'd64);
    tick();
    set_src(0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 64'hD2);
    settle();
    chk("t1_f3_eop", 64'(out_pkt_eop), 64'd1);
    chk("t1_f3_empty", 64'(out_pkt_empty), 64'd10);
    chk("t1_bytes_f2", stats_bytes, 64'd128);
    tick();
    set_src(0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0);
    settle();
    chk("t1_end_valid", 64'(out_pkt_valid), 64'd0);
    chk("t1_end_ready", 64'(in_pkt_ready), 64'd0);
    chk("t1_cnt0", 64'(stats_pkt_cnt[31:0]), 64'd1);
    chk("t1_bytes", stats_bytes, 64'd182);
    chk("t1_err", 64'(proto_err), 64'd0);

    // All four sources continuously eligible with single-flit packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_src(i, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'hA0 + 64'(i));
    end
    settle();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_bubble_valid_%0d", k), 64'(out_pkt_valid), 64'd0);
      chk($sformatf("t2_bubble_ready_%0d", k), 64'(in_pkt_ready), 64'd0);
      tick(); settle();
      chk($sformatf("t2_sel_%0d", k), 64'(out_sel), 64'(k % 4));
      chk($sformatf("t2_ready_%0d", k), 64'(in_pkt_ready), 64'(1 << (k % 4)));
      chk($sformatf("t2_data_%0d", k), out_pkt_data[63:0], 64'hA0 + 64'(k % 4));
      tick(); settle();
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t2_cnt_%0d", i), 64'(stats_pkt_cnt[i*32 +: 32]), 64'd2);
    end
    chk("t2_bytes", stats_bytes, 64'd512);

    // Only source 2 valid: grant 2 (ptr->3), then wrap-around grant to 2 again.
    clr_all();
    set_src(2, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'hC2);
    settle();
    tick(); settle();
    chk("t3_first_sel", 64'(out_sel), 64'd2);
    tick(); settle();
    tick(); settle();
    chk("t3_wrap_sel", 64'(out_sel), 64'd2);
    chk("t3_wrap_valid", 64'(out_pkt_valid), 64'd1);
    tick();
    clr_all();
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'hC0);
    set_src(3, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'hC3);
    settle();
    tick(); settle();
    chk("t3_ptr_is_3", 64'(out_sel), 64'd3);
    tick();
    clr_all();
    settle();
    chk("t3_cnt2", 64'(stats_pkt_cnt[95:64]), 64'd4);
    chk("t3_cnt3", 64'(stats_pkt_cnt[127:96]), 64'd3);
    chk("t3_bytes", stats_bytes, 64'd704);

    // Metadata held back while the packet completes; grant persists.
    set_src(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'hB1);
    out_meta_ready = 1'b0;
    settle();
    tick(); settle();
    chk("t4_sel", 64'(out_sel), 64'd1);
    chk("t4_meta_valid", 64'(out_meta_valid), 64'd1);
    chk("t4_meta_ready_held", 64'(in_meta_ready), 64'd0);
    chk("t4_pkt_ready", 64'(in_pkt_ready), 64'd2);
    tick(); settle();
    chk("t4_pkt_masked", 64'(out_pkt_valid), 64'd0);
    chk("t4_meta_still", 64'(out_meta_valid), 64'd1);
    chk("t4_sel_c2", 64'(out_sel), 64'd1);
    tick(); settle();
    chk("t4_sel_c3", 64'(out_sel), 64'd1);
    tick(); settle();
    chk("t4_pkt_ready_off", 64'(in_pkt_ready), 64'd0);
    tick();
    out_meta_ready = 1'b1;
    settle();
    chk("t4_meta_hs", 64'(in_meta_ready), 64'd2);
    tick();
    clr_all();
    set_src(2, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 64'hE0);
    out_meta_ready = 1'b0;
    settle();
    chk("t4_idle_meta", 64'(out_meta_valid), 64'd0);
    chk("t4_cnt1", 64'(stats_pkt_cnt[63:32]), 64'd3);
    // Same-cycle final handshakes on source 2, then source 3 must follow.
    tick(); settle();
    chk("t4b_sel", 64'(out_sel), 64'd2);
    chk("t4b_f1_ready", 64'(in_pkt_ready), 64'd4);
    tick();
    set_src(2, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 64'hE1);
    out_meta_ready = 1'b1;
    settle();
    chk("t4b_meta_ready", 64'(in_meta_ready), 64'd4);
    chk("t4b_pkt_ready", 64'(in_pkt_ready), 64'd4);
    tick();
    clr_all();
    set_src(3, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'hF3);
    settle();
    chk("t4b_idle_valid", 64'(out_pkt_valid), 64'd0);
    chk("t4b_idle_ready", 64'(in_pkt_ready), 64'd0);
    tick(); settle();
    chk("t4b_next_sel", 64'(out_sel), 64'd3);
    chk("t4b_next_valid", 64'(out_pkt_valid), 64'd1);
    tick();
    clr_all();
    settle();
    chk("t4b_cnt2", 64'(stats_pkt_cnt[95:64]), 64'd5);
    chk("t4b_bytes", stats_bytes, 64'd960);

    // First flit without sop: forwarded, counted, proto_err set and sticky.
    set_src(0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 64'h50);
    settle();
    tick(); settle();
    chk("t5a_forwarded", 64'(out_pkt_valid), 64'd1);
    chk("t5a_err_before", 64'(proto_err), 64'd0);
    tick();
    clr_all();
    set_src(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'h51);
    settle();
    chk("t5a_err", 64'(proto_err), 64'd1);
    chk("t5a_cnt0", 64'(stats_pkt_cnt[31:0]), 64'd3);
    tick(); settle();
    chk("t5a_clean_sel", 64'(out_sel), 64'd1);
    tick();
    clr_all();
    settle();
    chk("t5a_sticky", 64'(proto_err), 64'd1);
    chk("t5a_cnt1", 64'(stats_pkt_cnt[63:32]), 64'd4);

    // sop repeated on flit 2.
    do_reset();
    chk("t5b_err_reset", 64'(proto_err), 64'd0);
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 64'h60);
    settle();
    tick(); settle();
    tick();
    set_src(0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 64'h61);
    settle();
    chk("t5b_err_before", 64'(proto_err), 64'd0);
    chk("t5b_f2_valid", 64'(out_pkt_valid), 64'd1);
    tick();
    clr_all();
    settle();
    chk("t5b_err", 64'(proto_err), 64'd1);
    chk("t5b_cnt0", 64'(stats_pkt_cnt[31:0]), 64'd1);
    chk("t5b_bytes", stats_bytes, 64'd128);

    // Reset on flit 2 of a 4-flit packet from source 1.
    set_src(1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 64'h70);
    settle();
    tick(); settle();
    chk("t6_sel", 64'(out_sel), 64'd1);
    tick();
    set_src(1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 64'h71);
    settle();
    chk("t6_f2_data", out_pkt_data[63:0], 64'h71);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 64'h80);
    settle();
    chk_zero("t6_abort");
    tick(); settle();
    chk("t6_ptr_reset", 64'(out_sel), 64'd0);
    chk("t6_regrant_valid", 64'(out_pkt_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parser_rr_arb.md
# parser_rr_arb

Packet-granular round-robin arbiter that shares one parser instance between NUM_IN independent packet+metadata sources. It sits directly in front of the parser's in_pkt_* / in_meta_* ports. It grants one source at a time and holds that grant from the metadata flit through the packet's eop flit. Per-source packet counts, a total byte count and a sticky protocol-error flag are exported for the stats path.

## Interface
Parameters:
- NUM_IN, 4: number of requesting sources (2..8)
- DATA_WIDTH, 512: packet flit width in bits
- EMPTY_WIDTH, 6: width of the empty field, in bytes-unused on the eop flit
- META_WIDTH, $bits(metadata_t): metadata flit width

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- in_pkt_data  in  NUM_IN*DATA_WIDTH  per-source flit; source i occupies slice i
- in_pkt_valid / in_pkt_sop / in_pkt_eop  in  NUM_IN  per-source flags
- in_pkt_empty  in  NUM_IN*EMPTY_WIDTH  per-source empty
- in_pkt_ready  out  NUM_IN  per-source ready
- in_meta_data  in  NUM_IN*META_WIDTH  per-source metadata
- in_meta_valid  in  NUM_IN; in_meta_ready  out  NUM_IN
- out_pkt_data / _valid / _sop / _eop / _empty  out  DATA_WIDTH/1/1/1/EMPTY_WIDTH  to parser; out_pkt_ready  in  1
- out_meta_data / _valid  out  META_WIDTH/1; out_meta_ready  in  1
- out_sel  out  $clog2(NUM_IN)  currently granted source
- stats_pkt_cnt  out  NUM_IN*32  per-source completed packets, wrapping
- stats_bytes  out  64  total packet bytes forwarded, wrapping
- proto_err  out  1  sticky SOP/EOP framing error

## Operation
- States: IDLE, GRANT.
- IDLE:
  - All out valids and all in readies are 0.
  - Source i is eligible when in_meta_valid[i] & in_pkt_valid[i].
  - Search starts at rr_ptr and ascends modulo NUM_IN; the first eligible source g is registered into out_sel.
  - meta_done and pkt_done are cleared. Transition to GRANT.
  - If no source is eligible, stay in IDLE.
- GRANT:
  - Source g is passed through combinationally; every other source's readies are 0.
  - Metadata path is active while !meta_done: out_meta_valid = in_meta_valid[g], in_meta_ready[g] = out_meta_ready. A handshake sets meta_done, and out_meta_valid is 0 after that.
  - Packet path is active while !pkt_done: out_pkt_valid = in_pkt_valid[g], in_pkt_ready[g] = out_pkt_ready. An accepted flit with eop sets pkt_done.
  - The metadata and packet paths progress independently in the same cycles.
- Exit from GRANT:
  - Leave when both paths are done, including when the final handshakes land in the same cycle.
  - On exit: rr_ptr <= (g+1) mod NUM_IN, state returns to IDLE.
- Framing check:
  - The first accepted flit of a grant must carry sop.
  - Any later flit in the same grant carrying sop is an error.
  - Either case sets proto_err, which holds until rst. Forwarding is unaffected.
- Stats:
  - On an accepted eop flit, stats_pkt_cnt[g] increments by 1.
  - On every accepted flit, stats_bytes adds DATA_WIDTH/8. On an eop flit it adds DATA_WIDTH/8 − empty instead.
  - All counters wrap modulo 2^width.
- A single-flit packet (sop&eop) is legal and completes the packet path in one handshake.

## Timing
- Reset values: state IDLE, rr_ptr 0, out_sel 0, meta_done/pkt_done 0, all out valids 0, all in readies 0, stats 0, proto_err 0.
- Arbitration costs 1 cycle (IDLE). Data and metadata are zero-latency pass-through during GRANT.
- Back-to-back packets see exactly one idle bubble cycle between grants.
- Minimum grant: IDLE + 1 GRANT cycle when the metadata and a single-flit packet both handshake immediately.
- Ready is never asserted to a non-granted source, including in the cycle a new grant is registered.
- rst mid-packet aborts the grant immediately. The partially forwarded packet is not counted, and the parser side must also be reset.
- out_sel is stable for the whole GRANT state.

## Test plan
- Single source 0: one 3-flit packet (last empty=10) plus metadata, parser always ready. Required: out_sel=0; flits appear in GRANT with zero latency; stats_pkt_cnt[0]=1; stats_bytes=182; state returns to IDLE.
- Sources 0..3 all continuously eligible with single-flit packets. Required: grant order 0,1,2,3,0,…; one bubble between grants; after 8 packets each stats_pkt_cnt is 2.
- Source 2 eligible with rr_ptr=3 and only source 2 valid. Required: wrap-around grant to 2, then rr_ptr=3.
- Parser holds out_meta_ready=0 while the packet completes, then asserts it 4 cycles later. Required: GRANT persists until the meta handshake. In a separate run with both final handshakes in the same cycle, the next cycle is IDLE.
- Granted source sends a first flit without sop, or sop on flit 2. Required: proto_err=1 and sticky; packet still forwarded; counts still update.
- rst asserted on flit 2 of a 4-flit packet. Required: next cycle has all valids/readies 0, out_sel=0, counters 0, proto_err 0.
